// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches from instruction memory over a req/ack handshake with a single
// outstanding request, parks a fetched word while decode is frozen, and
// redirects on a taken branch resolved in decode.
module if_stage_fetch #(
    parameter int unsigned            WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0]    RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                br_taken,
    input  logic [WORD_LEN-1:0] br_offset,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] id_instruction,
    output logic [WORD_LEN-1:0] id_pc_plus4,
    output logic                id_valid
);

    localparam logic [WORD_LEN-1:0] PC_STEP = WORD_LEN'(4);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nx;

    logic [WORD_LEN-1:0] r_pc;
    logic [WORD_LEN-1:0] r_buf;
    logic [WORD_LEN-1:0] r_saved;
    logic [WORD_LEN-1:0] r_id_instr;
    logic [WORD_LEN-1:0] r_id_pc4;
    logic                r_id_valid;
    logic                r_req;

    logic [WORD_LEN-1:0] w_pc_nx;
    logic [WORD_LEN-1:0] w_buf_nx;
    logic [WORD_LEN-1:0] w_saved_nx;
    logic [WORD_LEN-1:0] w_id_instr_nx;
    logic [WORD_LEN-1:0] w_id_pc4_nx;
    logic                w_id_valid_nx;
    logic                w_req_nx;

    logic [WORD_LEN-1:0] w_target;
    logic [WORD_LEN-1:0] w_pc_plus4;

    // Branch target is relative to the PC+4 of the branch sitting in decode.
    assign w_target   = r_id_pc4 + (br_offset << 2);
    assign w_pc_plus4 = r_pc + PC_STEP;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_START;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state and datapath update; redirect outranks ack and freeze.
    always_comb begin
        w_state_nx    = r_state;
        w_pc_nx       = r_pc;
        w_buf_nx      = r_buf;
        w_saved_nx    = r_saved;
        w_id_instr_nx = r_id_instr;
        w_id_pc4_nx   = r_id_pc4;
        w_id_valid_nx = r_id_valid;

        case (r_state)
            S_START: begin
                w_state_nx = S_WAIT;
                if (br_taken) begin
                    w_pc_nx       = w_target;
                    w_id_instr_nx = '0;
                    w_id_valid_nx = 1'b0;
                end
            end

            S_WAIT: begin
                if (br_taken) begin
                    w_id_instr_nx = '0;
                    w_id_valid_nx = 1'b0;
                    if (imem_ack) begin
                        w_pc_nx = w_target;
                    end else begin
                        // Old request still in flight: finish it, then jump.
                        w_saved_nx = w_target;
                        w_state_nx = S_DROP;
                    end
                end else if (imem_ack && !freeze) begin
                    w_id_instr_nx = imem_rdata;
                    w_id_pc4_nx   = w_pc_plus4;
                    w_id_valid_nx = 1'b1;
                    w_pc_nx       = w_pc_plus4;
                end else if (imem_ack) begin
                    w_buf_nx   = imem_rdata;
                    w_state_nx = S_HOLD;
                end else if (!freeze) begin
                    w_id_instr_nx = '0;
                    w_id_valid_nx = 1'b0;
                end
            end

            S_HOLD: begin
                if (br_taken) begin
                    w_id_instr_nx = '0;
                    w_id_valid_nx = 1'b0;
                    w_buf_nx      = '0;
                    w_pc_nx       = w_target;
                    w_state_nx    = S_WAIT;
                end else if (!freeze) begin
                    w_id_instr_nx = r_buf;
                    w_id_pc4_nx   = w_pc_plus4;
                    w_id_valid_nx = 1'b1;
                    w_pc_nx       = w_pc_plus4;
                    w_state_nx    = S_WAIT;
                end
            end

            S_DROP: begin
                w_id_instr_nx = '0;
                w_id_valid_nx = 1'b0;
                if (br_taken) begin
                    if (imem_ack) begin
                        w_pc_nx    = w_target;
                        w_state_nx = S_WAIT;
                    end else begin
                        w_saved_nx = w_target;
                    end
                end else if (imem_ack) begin
                    w_pc_nx    = r_saved;
                    w_state_nx = S_WAIT;
                end
            end

            default: begin
                w_state_nx = S_START;
            end
        endcase

        w_req_nx = (w_state_nx == S_WAIT) || (w_state_nx == S_DROP);
    end

    // PC, hold buffer, saved target, IF/ID register and request flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc       <= RESET_PC;
            r_buf      <= '0;
            r_saved    <= '0;
            r_id_instr <= '0;
            r_id_pc4   <= '0;
            r_id_valid <= 1'b0;
            r_req      <= 1'b0;
        end else begin
            r_pc       <= w_pc_nx;
            r_buf      <= w_buf_nx;
            r_saved    <= w_saved_nx;
            r_id_instr <= w_id_instr_nx;
            r_id_pc4   <= w_id_pc4_nx;
            r_id_valid <= w_id_valid_nx;
            r_req      <= w_req_nx;
        end
    end

    // The PC only moves when no request is pending, so it doubles as the
    // outstanding address in both WAIT and DROP.
    assign imem_req       = r_req;
    assign imem_addr      = r_pc;
    assign id_instruction = r_id_instr;
    assign id_pc_plus4    = r_id_pc4;
    assign id_valid       = r_id_valid;

endmodule
